// File: rtl/arith_unit_pkg.sv
// Shared word-format constants and helpers for the arithmetic unit and its
// ones'-complement adder.
package arith_unit_pkg;

  localparam int WORD_W   = 31;
  localparam int SIGN_BIT = WORD_W - 1;
  localparam int MAG_MSB  = WORD_W - 2;

  typedef logic [WORD_W-1:0] word_t;

  // Ones'-complement has two zeros; neither is normalised to the other.
  localparam word_t OC_POS_ZERO = '0;
  localparam word_t OC_NEG_ZERO = '1;

  // True when two or more request bits are set.
  function automatic logic multi_hot(input logic [4:0] req);
    return (req & (req - 5'd1)) != 5'd0;
  endfunction

endpackage

// File: rtl/arith_unit_oc_adder.sv
// Combinational ones'-complement adder with end-around carry and sign-rule
// overflow; shared with the op unit.
module oc_adder
  import arith_unit_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] sum,
  output logic              overflow
);

  logic [WORD_W:0] raw;

  // The second add can never carry again: the low word of a+b with a carry
  // out is at most all-ones minus one.
  always_comb begin
    raw      = {1'b0, a} + {1'b0, b};
    sum      = raw[WORD_W-1:0] + {{(WORD_W-1){1'b0}}, raw[WORD_W]};
    overflow = (a[SIGN_BIT] == b[SIGN_BIT]) && (sum[SIGN_BIT] != a[SIGN_BIT]);
  end

endmodule

// File: rtl/arith_unit.sv
// Arithmetic-unit datapath: working registers A, B, C updated by one-cycle
// operation pulses, with per-register priority and conflict detection.
module arith_unit
  import arith_unit_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              do_clear_a,
  input  logic              do_clear_b,
  input  logic              do_clear_c,
  input  logic              do_not_a,
  input  logic              do_not_b,
  input  logic              do_sum,
  input  logic              do_and,
  input  logic              do_set_c_30,
  input  logic              do_left_shift_b,
  input  logic              do_left_shift_c,
  input  logic              do_left_shift_c29,
  input  logic              do_right_shift_bc,
  input  logic              do_move_c_to_a,
  input  logic              do_move_c_to_b,
  input  logic              do_move_b_to_c,
  input  logic              do_load_b_from_mem,
  input  logic [WORD_W-1:0] mem_data_in,
  output logic [WORD_W-1:0] reg_a_to_mem,
  output logic              reg_a_sign,
  output logic              reg_b_sign,
  output logic              reg_c_sign,
  output logic              overflow,
  output logic              conflict_err
);

  word_t reg_a, reg_b, reg_c;
  word_t next_a, next_b, next_c;
  logic  ovf_q, next_ovf;
  logic  conflict_q, next_conflict;

  word_t sum_res;
  logic  sum_ovf;

  oc_adder u_adder (
    .a        (reg_a),
    .b        (reg_b),
    .sum      (sum_res),
    .overflow (sum_ovf)
  );

  logic c_shift_req;
  logic b_taken_above_rsh;
  logic c_taken_above_rsh;
  logic rsh_win;
  logic conflict_a, conflict_b, conflict_c;

  // NOTE: every signal written here gets a default first, so no path through
  // the priority chains can leave a value unassigned and infer a latch.
  always_comb begin
    c_shift_req       = do_right_shift_bc | do_left_shift_c | do_left_shift_c29;
    b_taken_above_rsh = do_clear_b | do_load_b_from_mem | do_move_c_to_b |
                        do_not_b | do_left_shift_b;
    c_taken_above_rsh = do_clear_c | do_move_b_to_c;
    // The BC shift is all-or-nothing: losing either half cancels both halves.
    rsh_win           = do_right_shift_bc & ~b_taken_above_rsh & ~c_taken_above_rsh;

    conflict_a = ~do_clear_a &
                 multi_hot({1'b0, do_move_c_to_a, do_sum, do_and, do_not_a});
    conflict_b = ~do_clear_b &
                 multi_hot({do_load_b_from_mem, do_move_c_to_b, do_not_b,
                            do_left_shift_b, do_right_shift_bc});
    // set_c_30 merges with a C shift (quotient-bit idiom), so it only counts
    // as a competing writer when no shift of C is requested.
    conflict_c = ~do_clear_c &
                 multi_hot({do_move_b_to_c, do_right_shift_bc, do_left_shift_c,
                            do_left_shift_c29, do_set_c_30 & ~c_shift_req});
    next_conflict = conflict_a | conflict_b | conflict_c;

    next_a   = reg_a;
    next_ovf = ovf_q;
    if (do_clear_a) begin
      next_a   = OC_POS_ZERO;
      next_ovf = 1'b0;
    end else if (do_move_c_to_a) begin
      next_a = reg_c;
    end else if (do_sum) begin
      next_a   = sum_res;
      next_ovf = ovf_q | sum_ovf;
    end else if (do_and) begin
      next_a = reg_a & reg_b;
    end else if (do_not_a) begin
      next_a = ~reg_a;
    end

    next_b = reg_b;
    if (do_clear_b)              next_b = OC_POS_ZERO;
    else if (do_load_b_from_mem) next_b = mem_data_in;
    else if (do_move_c_to_b)     next_b = reg_c;
    else if (do_not_b)           next_b = ~reg_b;
    else if (do_left_shift_b)    next_b = {reg_b[MAG_MSB:0], 1'b0};
    else if (rsh_win)            next_b = {reg_b[SIGN_BIT], reg_b[SIGN_BIT:1]};

    next_c = reg_c;
    if (do_clear_c) begin
      next_c = OC_POS_ZERO;
    end else if (do_move_b_to_c) begin
      next_c = reg_b;
    end else begin
      if (rsh_win)                next_c = {reg_c[SIGN_BIT], reg_b[0], reg_c[MAG_MSB:1]};
      else if (do_left_shift_c)   next_c = {reg_c[MAG_MSB:0], 1'b0};
      else if (do_left_shift_c29) next_c = {reg_c[SIGN_BIT], reg_c[MAG_MSB-1:0], 1'b0};
      if (do_set_c_30)            next_c[SIGN_BIT] = 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments so every operation sees
  // pre-edge values; this is what makes the simultaneous B/C move a swap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      reg_a      <= OC_POS_ZERO;
      reg_b      <= OC_POS_ZERO;
      reg_c      <= OC_POS_ZERO;
      ovf_q      <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      reg_a      <= next_a;
      reg_b      <= next_b;
      reg_c      <= next_c;
      ovf_q      <= next_ovf;
      conflict_q <= next_conflict;
    end
  end

  assign reg_a_to_mem = reg_a;
  assign reg_a_sign   = reg_a[SIGN_BIT];
  assign reg_b_sign   = reg_b[SIGN_BIT];
  assign reg_c_sign   = reg_c[SIGN_BIT];
  assign overflow     = ovf_q;
  assign conflict_err = conflict_q;

endmodule

// File: tb/tb_arith_unit.sv
// Self-checking bench for arith_unit: directed scenarios plus randomized pulse
// mixes checked against a behavioural model of the register rules.
module tb_arith_unit;

  typedef struct packed {
    logic clr_a, clr_b, clr_c, not_a, not_b, sum, and_op, set_c30;
    logic lsh_b, lsh_c, lsh_c29, rsh_bc, mv_ca, mv_cb, mv_bc, ld_b;
  } ops_t;

  localparam ops_t OP_NONE  = '0;
  localparam ops_t OP_CLR_A = '{clr_a:1'b1,   default:1'b0};
  localparam ops_t OP_NOT_A = '{not_a:1'b1,   default:1'b0};
  localparam ops_t OP_NOT_B = '{not_b:1'b1,   default:1'b0};
  localparam ops_t OP_SUM   = '{sum:1'b1,     default:1'b0};
  localparam ops_t OP_AND   = '{and_op:1'b1,  default:1'b0};
  localparam ops_t OP_SET30 = '{set_c30:1'b1, default:1'b0};
  localparam ops_t OP_LSH_C = '{lsh_c:1'b1,   default:1'b0};
  localparam ops_t OP_RSH   = '{rsh_bc:1'b1,  default:1'b0};
  localparam ops_t OP_MV_CA = '{mv_ca:1'b1,   default:1'b0};
  localparam ops_t OP_MV_CB = '{mv_cb:1'b1,   default:1'b0};
  localparam ops_t OP_MV_BC = '{mv_bc:1'b1,   default:1'b0};
  localparam ops_t OP_LD_B  = '{ld_b:1'b1,    default:1'b0};

  logic        clk = 1'b0;
  logic        resetn;
  ops_t        cur;
  logic [30:0] mem_data_in;
  logic [30:0] reg_a_to_mem;
  logic        reg_a_sign, reg_b_sign, reg_c_sign, overflow, conflict_err;

  int checks = 0;
  int passed = 0;

  // Reference state: what the registers should hold after the last edge.
  logic [30:0] ma, mb, mc;
  logic        movf, mconf;

  always #5 clk = ~clk;

  arith_unit dut (
    .clk               (clk),
    .resetn            (resetn),
    .do_clear_a        (cur.clr_a),
    .do_clear_b        (cur.clr_b),
    .do_clear_c        (cur.clr_c),
    .do_not_a          (cur.not_a),
    .do_not_b          (cur.not_b),
    .do_sum            (cur.sum),
    .do_and            (cur.and_op),
    .do_set_c_30       (cur.set_c30),
    .do_left_shift_b   (cur.lsh_b),
    .do_left_shift_c   (cur.lsh_c),
    .do_left_shift_c29 (cur.lsh_c29),
    .do_right_shift_bc (cur.rsh_bc),
    .do_move_c_to_a    (cur.mv_ca),
    .do_move_c_to_b    (cur.mv_cb),
    .do_move_b_to_c    (cur.mv_bc),
    .do_load_b_from_mem(cur.ld_b),
    .mem_data_in       (mem_data_in),
    .reg_a_to_mem      (reg_a_to_mem),
    .reg_a_sign        (reg_a_sign),
    .reg_b_sign        (reg_b_sign),
    .reg_c_sign        (reg_c_sign),
    .overflow          (overflow),
    .conflict_err      (conflict_err)
  );

  // Behavioural model: sum as plain integer arithmetic with wrap-around,
  // writers counted per register, highest-priority request wins.
  task automatic model_step(input ops_t o, input logic [30:0] mem);
    longint      s;
    logic [30:0] sum_v, na, nb, nc;
    logic        sum_ovf, c_shift, rsh_ok;
    int          wa, wb, wc;
    s = longint'(ma) + longint'(mb);
    if (s >= 64'h8000_0000) s = s - 64'h8000_0000 + 1;
    sum_v   = s[30:0];
    sum_ovf = (ma[30] == mb[30]) && (sum_v[30] != ma[30]);

    c_shift = o.rsh_bc || o.lsh_c || o.lsh_c29;
    rsh_ok  = o.rsh_bc && !(o.clr_b || o.ld_b || o.mv_cb || o.not_b || o.lsh_b)
                       && !(o.clr_c || o.mv_bc);
    wa = int'(o.mv_ca) + int'(o.sum) + int'(o.and_op) + int'(o.not_a);
    wb = int'(o.ld_b) + int'(o.mv_cb) + int'(o.not_b) + int'(o.lsh_b) + int'(o.rsh_bc);
    wc = int'(o.mv_bc) + int'(o.rsh_bc) + int'(o.lsh_c) + int'(o.lsh_c29) +
         int'(o.set_c30 && !c_shift);

    na = ma;
    if (o.clr_a)       begin na = '0; movf = 1'b0; end
    else if (o.mv_ca)  na = mc;
    else if (o.sum)    begin na = sum_v; if (sum_ovf) movf = 1'b1; end
    else if (o.and_op) na = ma & mb;
    else if (o.not_a)  na = ~ma;

    nb = mb;
    if (o.clr_b)      nb = '0;
    else if (o.ld_b)  nb = mem;
    else if (o.mv_cb) nb = mc;
    else if (o.not_b) nb = ~mb;
    else if (o.lsh_b) nb = mb << 1;
    else if (rsh_ok)  nb = {mb[30], mb[30:1]};

    nc = mc;
    if (o.clr_c) nc = '0;
    else if (o.mv_bc) nc = mb;
    else begin
      if (rsh_ok)         nc = {mc[30], mb[0], mc[29:1]};
      else if (o.lsh_c)   nc = mc << 1;
      else if (o.lsh_c29) nc = {mc[30], mc[28:0], 1'b0};
      if (o.set_c30) nc[30] = 1'b1;
    end

    mconf = (!o.clr_a && wa >= 2) || (!o.clr_b && wb >= 2) || (!o.clr_c && wc >= 2);
    ma = na; mb = nb; mc = nc;
  endtask

  task automatic model_reset();
    ma = '0; mb = '0; mc = '0; movf = 1'b0; mconf = 1'b0;
  endtask

  // One pulse cycle: drive on the falling edge, sampled by the rising edge,
  // outputs settled 1 time unit later.
  task automatic step(input ops_t o, input logic [30:0] mem = '0);
    @(negedge clk);
    cur = o;
    mem_data_in = mem;
    @(posedge clk);
    model_step(o, mem);
    #1;
    cur = OP_NONE;
  endtask

  task automatic load_b(input logic [30:0] v);
    step(OP_LD_B, v);
  endtask

  task automatic load_c(input logic [30:0] v);
    load_b(v);
    step(OP_MV_BC);
  endtask

  task automatic load_a(input logic [30:0] v);
    load_c(v);
    step(OP_MV_CA);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cur = OP_NONE;
    mem_data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({reg_a_to_mem, reg_a_sign, reg_b_sign, reg_c_sign, overflow, conflict_err} !== 36'd0)
      $display("FAIL reset_state: A=%h sa=%b sb=%b sc=%b ovf=%b cerr=%b, required all 0",
               reg_a_to_mem, reg_a_sign, reg_b_sign, reg_c_sign, overflow, conflict_err);
    else passed++;
    @(negedge clk);
    resetn = 1'b1;
    model_reset();

    // Reset asserted together with a sum pulse: clears at once, sum is lost.
    load_a(31'd5);
    load_b(31'd3);
    @(negedge clk);
    cur = OP_SUM;
    resetn = 1'b0;
    #1;
    checks++;
    if ({reg_a_to_mem, reg_b_sign, reg_c_sign, overflow} !== 34'd0)
      $display("FAIL reset_mid_sum_async: A=%h sb=%b sc=%b ovf=%b, required 0",
               reg_a_to_mem, reg_b_sign, reg_c_sign, overflow);
    else passed++;
    @(negedge clk);
    cur = OP_NONE;
    resetn = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if ({reg_a_to_mem, overflow} !== 32'd0)
      $display("FAIL reset_mid_sum_held: A=%h ovf=%b, required 0", reg_a_to_mem, overflow);
    else passed++;
    step(OP_MV_CA);
    checks++;
    if (reg_a_to_mem !== 31'd0)
      $display("FAIL reset_c_zero: C=%h, required 0", reg_a_to_mem);
    else passed++;
    step(OP_MV_BC);
    step(OP_MV_CA);
    checks++;
    if (reg_a_to_mem !== 31'd0)
      $display("FAIL reset_b_zero: B=%h, required 0", reg_a_to_mem);
    else passed++;
  endtask

  task automatic test_sum();
    load_a(31'h7FFF_FFFE);
    load_b(31'd2);
    step(OP_SUM);
    checks++;
    if ({reg_a_to_mem, overflow} !== {31'd1, 1'b0})
      $display("FAIL sum_end_around: A=%h ovf=%b, required 00000001 0", reg_a_to_mem, overflow);
    else passed++;

    load_a(31'h3FFF_FFFF);
    load_b(31'h3FFF_FFFF);
    step(OP_SUM);
    checks++;
    if ({reg_a_to_mem, overflow} !== {31'h7FFF_FFFE, 1'b1})
      $display("FAIL sum_overflow: A=%h ovf=%b, required 7ffffffe 1", reg_a_to_mem, overflow);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      step(OP_SUM);
      checks++;
      if (overflow !== 1'b1)
        $display("FAIL overflow_sticky[%0d]: ovf=%b, required 1", i, overflow);
      else passed++;
    end
    step(OP_CLR_A);
    checks++;
    if ({reg_a_to_mem, overflow} !== 32'd0)
      $display("FAIL clear_a_ovf: A=%h ovf=%b, required 0 0", reg_a_to_mem, overflow);
    else passed++;

    // Clear and an overflowing sum in the same cycle: overflow stays clear.
    load_a(31'h3FFF_FFFF);
    step(OP_CLR_A | OP_SUM);
    checks++;
    if ({reg_a_to_mem, overflow, conflict_err} !== 33'd0)
      $display("FAIL clear_with_sum: A=%h ovf=%b cerr=%b, required 0 0 0",
               reg_a_to_mem, overflow, conflict_err);
    else passed++;

    // Negative zero is not normalised.
    load_a(31'h7FFF_FFFF);
    load_b(31'd0);
    step(OP_SUM);
    checks++;
    if ({reg_a_to_mem, overflow} !== {31'h7FFF_FFFF, 1'b0})
      $display("FAIL neg_zero_kept: A=%h ovf=%b, required 7fffffff 0", reg_a_to_mem, overflow);
    else passed++;
  endtask

  task automatic test_swap();
    load_c(31'h4000_0022);
    load_b(31'h0000_0011);
    step(OP_MV_BC | OP_MV_CB);
    checks++;
    if ({reg_b_sign, reg_c_sign, conflict_err} !== 3'b100)
      $display("FAIL swap_flags: sb=%b sc=%b cerr=%b, required 1 0 0",
               reg_b_sign, reg_c_sign, conflict_err);
    else passed++;
    step(OP_MV_CA);
    checks++;
    if (reg_a_to_mem !== 31'h0000_0011)
      $display("FAIL swap_c: C=%h, required 00000011", reg_a_to_mem);
    else passed++;
    step(OP_MV_BC);
    step(OP_MV_CA);
    checks++;
    if (reg_a_to_mem !== 31'h4000_0022)
      $display("FAIL swap_b: B=%h, required 40000022", reg_a_to_mem);
    else passed++;
  endtask

  task automatic test_shift();
    load_c(31'd0);
    load_b(31'h4000_0001);
    step(OP_RSH);
    checks++;
    if ({reg_b_sign, reg_c_sign, conflict_err} !== 3'b100)
      $display("FAIL rsh_flags: sb=%b sc=%b cerr=%b, required 1 0 0",
               reg_b_sign, reg_c_sign, conflict_err);
    else passed++;
    step(OP_MV_CA);
    checks++;
    if (reg_a_to_mem !== 31'h2000_0000)
      $display("FAIL rsh_c: C=%h, required 20000000", reg_a_to_mem);
    else passed++;
    step(OP_LSH_C | OP_SET30);
    checks++;
    if ({reg_c_sign, conflict_err} !== 2'b10)
      $display("FAIL lsh_set30_flags: sc=%b cerr=%b, required 1 0", reg_c_sign, conflict_err);
    else passed++;
    step(OP_MV_CA);
    checks++;
    if (reg_a_to_mem !== 31'h4000_0000)
      $display("FAIL lsh_set30_c: C=%h, required 40000000", reg_a_to_mem);
    else passed++;
    step(OP_MV_BC);
    step(OP_MV_CA);
    checks++;
    if (reg_a_to_mem !== 31'h6000_0000)
      $display("FAIL rsh_b: B=%h, required 60000000", reg_a_to_mem);
    else passed++;
  endtask

  task automatic test_conflict();
    load_b(31'h55);
    step(OP_NOT_B | OP_LD_B, 31'h123);
    checks++;
    if (conflict_err !== 1'b1)
      $display("FAIL conflict_pulse: cerr=%b, required 1", conflict_err);
    else passed++;
    step(OP_NONE);
    checks++;
    if (conflict_err !== 1'b0)
      $display("FAIL conflict_one_cycle: cerr=%b, required 0", conflict_err);
    else passed++;
    step(OP_MV_BC);
    step(OP_MV_CA);
    checks++;
    if (reg_a_to_mem !== 31'h123)
      $display("FAIL conflict_winner: B=%h, required 00000123", reg_a_to_mem);
    else passed++;
  endtask

  task automatic test_and_not();
    load_a(31'h0F0F_0F0F);
    load_b(31'h00FF_00FF);
    step(OP_AND);
    checks++;
    if (reg_a_to_mem !== 31'h000F_000F)
      $display("FAIL and: A=%h, required 000f000f", reg_a_to_mem);
    else passed++;
    step(OP_NOT_A);
    checks++;
    if ({reg_a_to_mem, reg_a_sign} !== {31'h7FF0_FFF0, 1'b1})
      $display("FAIL not_a: A=%h sa=%b, required 7ff0fff0 1", reg_a_to_mem, reg_a_sign);
    else passed++;
  endtask

  task automatic test_random();
    logic [15:0] bits;
    logic [30:0] mem;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 16; i++) bits[i] = ($urandom_range(6) == 0);
      mem = 31'($urandom);
      step(ops_t'(bits), mem);
      checks++;
      if ({reg_a_to_mem, reg_a_sign, reg_b_sign, reg_c_sign, overflow, conflict_err} !==
          {ma, ma[30], mb[30], mc[30], movf, mconf})
        $display("FAIL random[%0d] ops=%h: A=%h s=%b%b%b ovf=%b cerr=%b, required A=%h s=%b%b%b ovf=%b cerr=%b",
                 n, bits, reg_a_to_mem, reg_a_sign, reg_b_sign, reg_c_sign, overflow, conflict_err,
                 ma, ma[30], mb[30], mc[30], movf, mconf);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_sum();
    test_swap();
    test_shift();
    test_conflict();
    test_and_not();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
